// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline staging logic.
//   skid_state_t : occupancy-encoded state of a two-entry skid stage
//   NOP_WORD     : instruction word used as the bubble payload
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam logic [15:0] NOP_WORD = 16'hF000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk     : clock
//   reset_n : synchronous active-low reset, clears count
//   inc     : advance by one unless already at all-ones
//   count   : current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage with registered ready/valid.
//   clk, reset_n       : clock, synchronous active-low reset
//   flush              : drop everything held and the incoming payload
//   in_valid/in_ready  : upstream handshake, in_data payload
//   out_valid/out_ready: downstream handshake, out_data payload (BUBBLE when empty)
//   occupancy          : number of held payloads (0..2)
//   stall_cycles       : saturating count of cycles with out_valid & !out_ready
//
// state | meaning
// EMPTY | nothing held, main = skid = BUBBLE
// ONE   | main holds the oldest payload, skid = BUBBLE
// FULL  | main holds the oldest, skid the next; upstream is stalled
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(NOP_WORD),
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cycles
);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, out_valid_q;
    logic             accept, pop;

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            main_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            // Handshake flags are registered copies of the next-state decode
            // so neither depends combinationally on this cycle's inputs.
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (pop && !accept) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE;
                    end else if (pop && accept) begin
                        main_d  = in_data;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (out_valid_q & ~out_ready & ~flush),
        .count  (stall_cycles)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready, out_valid;
    logic [15:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cycles;

    logic        s_in_ready, s_out_valid;
    logic [15:0] s_out_data;
    logic [1:0]  s_occupancy;
    logic [3:0]  s_stall;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q[$];
    int          stall16_m = 0;
    int          stall4_m  = 0;

    always #5 clk = ~clk;

    pipe_skid_stage dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .occupancy   (occupancy),
        .stall_cycles(stall_cycles)
    );

    pipe_skid_stage #(
        .CNT_W(4)
    ) dut_s (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (s_in_ready),
        .in_data     (in_data),
        .out_valid   (s_out_valid),
        .out_ready   (out_ready),
        .out_data    (s_out_data),
        .occupancy   (s_occupancy),
        .stall_cycles(s_stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic r, input logic f);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    // Scoreboard monitor: compares DUT state against the model, then advances
    // the model with the events that take effect at the next rising edge.
    always @(negedge clk) begin
        int          sz;
        logic [15:0] front;
        sz    = exp_q.size();
        front = (sz > 0) ? exp_q[0] : 16'hF000;

        check("occupancy", {30'd0, occupancy}, sz);
        check("in_ready", {31'd0, in_ready}, {31'd0, sz != 2});
        check("out_valid", {31'd0, out_valid}, {31'd0, sz != 0});
        check("out_data", {16'd0, out_data}, {16'd0, front});
        check("stall16", {16'd0, stall_cycles}, stall16_m);
        check("s_occupancy", {30'd0, s_occupancy}, sz);
        check("s_in_ready", {31'd0, s_in_ready}, {31'd0, sz != 2});
        check("s_out_valid", {31'd0, s_out_valid}, {31'd0, sz != 0});
        check("s_out_data", {16'd0, s_out_data}, {16'd0, front});
        check("stall4", {28'd0, s_stall}, stall4_m);

        if (!reset_n) begin
            exp_q.delete();
            stall16_m = 0;
            stall4_m  = 0;
        end else begin
            if (sz > 0 && !out_ready && !flush) begin
                if (stall16_m < 65535) stall16_m++;
                if (stall4_m < 15) stall4_m++;
            end
            if (sz > 0 && out_ready) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            else if (in_valid && sz < 2) exp_q.push_back(in_data);
        end
    end

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Idle after reset
        @(posedge clk);
        #1;
        check("rst_occ", {30'd0, occupancy}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'h0000F000);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_stall", {16'd0, stall_cycles}, 32'd0);

        // Streaming with out_ready high
        for (int i = 1; i <= 4; i++) drive(1'b1, 16'(i), 1'b1, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        #1 check("stream_last", {16'd0, out_data}, 32'd4);
        repeat (2) drive(1'b0, 16'h0, 1'b1, 1'b0);

        // Backpressure
        drive(1'b1, 16'h000A, 1'b0, 1'b0);
        drive(1'b1, 16'h000B, 1'b0, 1'b0);
        drive(1'b1, 16'h000C, 1'b0, 1'b0);
        #1;
        check("bp_occ", {30'd0, occupancy}, 32'd2);
        check("bp_ready", {31'd0, in_ready}, 32'd0);
        check("bp_data", {16'd0, out_data}, 32'h0000000A);
        drive(1'b1, 16'h000C, 1'b0, 1'b0);
        @(posedge clk);
        #1 check("bp_stall", {16'd0, stall_cycles}, 32'd3);
        drive(1'b1, 16'h000C, 1'b1, 1'b0);
        drive(1'b1, 16'h000C, 1'b1, 1'b0);
        repeat (4) drive(1'b0, 16'h0, 1'b1, 1'b0);

        // Flush from FULL with a simultaneous offer
        drive(1'b1, 16'h00A1, 1'b0, 1'b0);
        drive(1'b1, 16'h00B1, 1'b0, 1'b0);
        drive(1'b1, 16'h000D, 1'b0, 1'b1);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        #1;
        check("flush_occ", {30'd0, occupancy}, 32'd0);
        check("flush_data", {16'd0, out_data}, 32'h0000F000);
        check("flush_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) drive(1'b0, 16'h0, 1'b1, 1'b0);

        // Reset mid-operation from FULL, then saturation
        drive(1'b1, 16'h0011, 1'b0, 1'b0);
        drive(1'b1, 16'h0022, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0055;
        #1;
        check("mid_rst_occ", {30'd0, occupancy}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_stall", {16'd0, stall_cycles}, 32'd0);
        repeat (20) drive(1'b0, 16'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("sat_stall4", {28'd0, s_stall}, 32'd15);
        check("sat_stall16", {16'd0, stall_cycles}, 32'd20);
        check("sat_data", {16'd0, out_data}, 32'h00000055);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);

        // Random traffic, with in_ready probed for combinational dependence
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            reset_n   = ($urandom_range(0, 999) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            if ((c % 16) == 0) begin
                logic ir0;
                ir0       = in_ready;
                out_ready = ~out_ready;
                in_valid  = ~in_valid;
                #1 check("in_ready_comb", {31'd0, in_ready}, {31'd0, ir0});
                out_ready = ~out_ready;
                in_valid  = ~in_valid;
            end
        end

        drive(1'b0, 16'h0, 1'b1, 1'b0);
        reset_n = 1'b1;
        repeat (4) drive(1'b0, 16'h0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
